// File: rtl/cw305_axi_mailbox.sv
// cw305_axi_mailbox
// AXI4-Lite slave mailbox between the CW305 host capture interface and the
// picorv32 memory port. A host start snapshots host_in and raises host_busy.
// Firmware then reads the input words, writes the result words and commits
// them through STATUS. The commit drives host_out and pulses host_done.
//
// Ports:
//   clk, resetn        system clock and asynchronous active-low reset
//   host_start         start request, sampled every cycle
//   host_in            IN_WORDS x 32-bit input vector (word i = [32i+31:32i])
//   host_out           OUT_WORDS x 32-bit committed result
//   host_busy          high from an accepted start until commit
//   host_done          one-cycle pulse on commit (or watchdog expiry)
//   mem_axi_*          AXI4-Lite slave (AW, W, B, AR, R channels)
//
// Register map (addr[11:0] decoded):
//   0x000+4i input word i (RO)   0x100+4j output word j (RW, byte strobes)
//   0x200 STATUS / COMMIT        0x204 SEQ (accepted-start count, RO)
//
// Optional feature macro: CW305_AXI_TIMEOUT_EN enables the busy watchdog.
module cw305_axi_mailbox #(
    parameter int unsigned IN_WORDS       = 8,
    parameter int unsigned OUT_WORDS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    host_start,
    input  logic [32*IN_WORDS-1:0]  host_in,
    output logic [32*OUT_WORDS-1:0] host_out,
    output logic                    host_busy,
    output logic                    host_done,
    input  logic                    mem_axi_awvalid,
    output logic                    mem_axi_awready,
    input  logic [31:0]             mem_axi_awaddr,
    input  logic [2:0]              mem_axi_awprot,
    input  logic                    mem_axi_wvalid,
    output logic                    mem_axi_wready,
    input  logic [31:0]             mem_axi_wdata,
    input  logic [3:0]              mem_axi_wstrb,
    output logic                    mem_axi_bvalid,
    input  logic                    mem_axi_bready,
    input  logic                    mem_axi_arvalid,
    output logic                    mem_axi_arready,
    input  logic [31:0]             mem_axi_araddr,
    input  logic [2:0]              mem_axi_arprot,
    output logic                    mem_axi_rvalid,
    input  logic                    mem_axi_rready,
    output logic [31:0]             mem_axi_rdata
);

    localparam int unsigned  AW          = 12;
    localparam logic [AW-1:0] ADDR_STATUS = 12'h200;
    localparam logic [AW-1:0] ADDR_SEQ    = 12'h204;
    localparam logic [31:0]  RD_UNMAPPED = 32'hDEAD_BEEF;

    // AXI channel state
    logic          awready_q, awready_d;
    logic          aw_full_q, aw_full_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic          wready_q, wready_d;
    logic          w_full_q, w_full_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          bvalid_q, bvalid_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;

    // Mailbox state
    logic [31:0]              in_q  [IN_WORDS];
    logic [31:0]              in_d  [IN_WORDS];
    logic [31:0]              out_q [OUT_WORDS];
    logic [31:0]              out_d [OUT_WORDS];
    logic [32*OUT_WORDS-1:0]  host_out_q, host_out_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     ovr_q, ovr_d;
    logic                     tmo_q, tmo_d;
    logic [31:0]              seq_q, seq_d;
    logic                     start_hold_q, start_hold_d;

    logic        wr_fire, rd_fire, commit, clr_ovr, start_hit;
    logic [31:0] rd_val;

    assign host_out        = host_out_q;
    assign host_busy       = busy_q;
    assign host_done       = done_q;
    assign mem_axi_awready = awready_q;
    assign mem_axi_wready  = wready_q;
    assign mem_axi_bvalid  = bvalid_q;
    assign mem_axi_arready = arready_q;
    assign mem_axi_rvalid  = rvalid_q;
    assign mem_axi_rdata   = rdata_q;

    logic unused_ok;
    assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot,
                         mem_axi_awaddr[31:12], mem_axi_araddr[31:12]};

`ifdef CW305_AXI_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clr_tmo;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    // Read decode of the presented AR address
    always_comb begin
        rd_val = RD_UNMAPPED;
        if (mem_axi_araddr[11:8] == 4'h0) begin
            for (int k = 0; k < int'(IN_WORDS); k++) begin
                if (mem_axi_araddr[7:2] == 6'(k)) rd_val = in_q[k];
            end
        end else if (mem_axi_araddr[11:8] == 4'h1) begin
            for (int k = 0; k < int'(OUT_WORDS); k++) begin
                if (mem_axi_araddr[7:2] == 6'(k)) rd_val = out_q[k];
            end
        end else if (mem_axi_araddr[11:0] == ADDR_STATUS) begin
            rd_val = {28'd0, tmo_q, 1'b0, ovr_q, busy_q};
        end else if (mem_axi_araddr[11:0] == ADDR_SEQ) begin
            rd_val = seq_q;
        end
    end

    // Next-state logic for AXI channels, registers and host handshake
    always_comb begin
        aw_full_d    = aw_full_q;
        aw_addr_d    = aw_addr_q;
        w_full_d     = w_full_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        in_d         = in_q;
        out_d        = out_q;
        host_out_d   = host_out_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ovr_d        = ovr_q;
        tmo_d        = tmo_q;
        seq_d        = seq_q;
        start_hold_d = start_hold_q;
        commit       = 1'b0;
        clr_ovr      = 1'b0;
`ifdef CW305_AXI_TIMEOUT_EN
        cnt_d        = cnt_q;
        clr_tmo      = 1'b0;
`endif

        // Ready pulses only while the matching latch is empty
        awready_d = mem_axi_awvalid && !aw_full_q && !awready_q;
        wready_d  = mem_axi_wvalid && !w_full_q && !wready_q;
        arready_d = mem_axi_arvalid && !arready_q && !rvalid_q;

        if (mem_axi_awvalid && awready_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = mem_axi_awaddr[11:0];
        end
        if (mem_axi_wvalid && wready_q) begin
            w_full_d = 1'b1;
            wdata_d  = mem_axi_wdata;
            wstrb_d  = mem_axi_wstrb;
        end

        if (bvalid_q && mem_axi_bready) bvalid_d = 1'b0;

        // Perform the write; latches free immediately so the next AW/W can
        // be accepted while the response is still pending
        wr_fire = aw_full_q && w_full_q && !bvalid_q;
        if (wr_fire) begin
            bvalid_d  = 1'b1;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            if (aw_addr_q[11:8] == 4'h1) begin
                for (int k = 0; k < int'(OUT_WORDS); k++) begin
                    if (aw_addr_q[7:2] == 6'(k)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) out_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end
            end else if (aw_addr_q == ADDR_STATUS) begin
                commit  = wdata_q[0];
                clr_ovr = wdata_q[1];
`ifdef CW305_AXI_TIMEOUT_EN
                clr_tmo = wdata_q[3];
`endif
            end
        end

        rd_fire = mem_axi_arvalid && arready_q;
        if (rvalid_q && mem_axi_rready) rvalid_d = 1'b0;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
        end

        // A start counts once per assertion; a held level is ignored
        start_hit = host_start && !start_hold_q;
        if (!host_start)    start_hold_d = 1'b0;
        else if (start_hit) start_hold_d = 1'b1;

        if (clr_ovr) ovr_d = 1'b0;
        // Start is judged against pre-commit busy, so commit+start overruns
        if (start_hit && busy_q) ovr_d = 1'b1;

        if (commit && busy_q) begin
            for (int k = 0; k < int'(OUT_WORDS); k++) host_out_d[32*k +: 32] = out_q[k];
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (start_hit && !busy_q) begin
            for (int k = 0; k < int'(IN_WORDS); k++) in_d[k] = host_in[32*k +: 32];
            busy_d = 1'b1;
            seq_d  = seq_q + 32'd1;
        end

`ifdef CW305_AXI_TIMEOUT_EN
        // Watchdog: counts busy cycles, any commit restarts the count
        if (clr_tmo) tmo_d = 1'b0;
        if (!busy_q || commit) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt_d      = '0;
            host_out_d = '0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            tmo_d      = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`endif
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awready_q    <= 1'b0;
            aw_full_q    <= 1'b0;
            aw_addr_q    <= '0;
            wready_q     <= 1'b0;
            w_full_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            for (int k = 0; k < int'(IN_WORDS); k++)  in_q[k]  <= '0;
            for (int k = 0; k < int'(OUT_WORDS); k++) out_q[k] <= '0;
            host_out_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            tmo_q        <= 1'b0;
            seq_q        <= '0;
            start_hold_q <= 1'b0;
`ifdef CW305_AXI_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            awready_q    <= awready_d;
            aw_full_q    <= aw_full_d;
            aw_addr_q    <= aw_addr_d;
            wready_q     <= wready_d;
            w_full_q     <= w_full_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            in_q         <= in_d;
            out_q        <= out_d;
            host_out_q   <= host_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
            tmo_q        <= tmo_d;
            seq_q        <= seq_d;
            start_hold_q <= start_hold_d;
`ifdef CW305_AXI_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_cw305_axi_mailbox.sv
// Scoreboard testbench for cw305_axi_mailbox: directed scenarios followed by
// randomized AXI/host traffic checked against a register-map level model.
module tb_cw305_axi_mailbox;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned OUT_W = 4;
    localparam int unsigned TMO   = 16;
    localparam int unsigned HOW   = 32*OUT_W;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              host_start = 1'b0;
    logic [32*IN_W-1:0] host_in = '0;
    logic [HOW-1:0]    host_out;
    logic              host_busy, host_done;
    logic              awvalid = 1'b0, awready;
    logic [31:0]       awaddr = '0;
    logic [2:0]        awprot = '0;
    logic              wvalid = 1'b0, wready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              bvalid, bready = 1'b0;
    logic              arvalid = 1'b0, arready;
    logic [31:0]       araddr = '0;
    logic [2:0]        arprot = '0;
    logic              rvalid, rready = 1'b0;
    logic [31:0]       rdata;

    always #5 clk = ~clk;

    cw305_axi_mailbox #(
        .IN_WORDS(IN_W), .OUT_WORDS(OUT_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .host_start(host_start), .host_in(host_in), .host_out(host_out),
        .host_busy(host_busy), .host_done(host_done),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
        .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
        .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
        .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
        .mem_axi_rdata(rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]    rd_q[$];
    logic [HOW-1:0] done_q[$];

    // Reference model of the mailbox register map
    logic [31:0]    m_in  [IN_W];
    logic [31:0]    m_out [OUT_W];
    logic [HOW-1:0] m_hout = '0;
    bit             m_busy = 0, m_ovr = 0, m_tmo = 0;
    logic [31:0]    m_seq = '0;

    function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void check_wide(string name, logic [HOW-1:0] act, logic [HOW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void fail_to(string name);
        n_checks++;
        $display("FAIL %s: got no response expected one within bound", name);
    endfunction

    function automatic logic [HOW-1:0] pack_out();
        logic [HOW-1:0] v;
        for (int j = 0; j < int'(OUT_W); j++) v[32*j +: 32] = m_out[j];
        return v;
    endfunction

    function automatic void model_start(logic [32*IN_W-1:0] v);
        if (!m_busy) begin
            for (int i = 0; i < int'(IN_W); i++) m_in[i] = v[32*i +: 32];
            m_busy = 1;
            m_seq  = m_seq + 32'd1;
        end else begin
            m_ovr = 1;
        end
    endfunction

    function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
        int unsigned off = 32'(a[11:0]);
        if (off >= 256 && off < 256 + 4*OUT_W) begin
            int unsigned j = (off - 256) / 4;
            for (int b = 0; b < 4; b++) if (s[b]) m_out[j][8*b +: 8] = d[8*b +: 8];
        end else if (off == 512) begin
            if (d[1]) m_ovr = 0;
            if (d[3]) m_tmo = 0;
            if (d[0] && m_busy) begin
                m_hout = pack_out();
                done_q.push_back(m_hout);
                m_busy = 0;
            end
        end
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        int unsigned off = 32'(a[11:0]);
        if (off < 4*IN_W) return m_in[off/4];
        if (off >= 256 && off < 256 + 4*OUT_W) return m_out[(off-256)/4];
        if (off == 512) return {28'd0, m_tmo, 1'b0, m_ovr, m_busy};
        if (off == 516) return m_seq;
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int unsigned s = $urandom_range(0, 4);
        case (s)
            0: a = 32'(4 * $urandom_range(0, IN_W + 2));
            1: a = 32'h100 + 32'(4 * $urandom_range(0, OUT_W + 2));
            2: a = 32'h200;
            3: a = 32'h204;
            default: a = {20'd0, 10'($urandom), 2'b00};
        endcase
        a[31:12] = 20'($urandom);
        return a;
    endfunction

    // Read-data monitor
    always @(negedge clk) begin
        if (resetn && rvalid && rready) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL rdata_unexpected: got %h expected no read", rdata);
            end else begin
                check32("rdata", rdata, rd_q.pop_front());
            end
        end
    end

    // Commit monitor
    always @(negedge clk) begin
        logic [HOW-1:0] e;
        if (resetn && host_done) begin
            if (done_q.size() == 0) begin
                n_checks++;
                $display("FAIL done_unexpected: got host_done=1 expected 0");
            end else begin
                e = done_q.pop_front();
                check_wide("host_out_at_done", host_out, e);
                check32("busy_at_done", 32'(host_busy), 32'd0);
            end
        end
    end

    task automatic send_aw(input logic [31:0] a);
        int t = 0;
        awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (awready) break;
            t++;
            if (t > 50) begin fail_to("awready"); break; end
        end
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int t = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (wready) break;
            t++;
            if (t > 50) begin fail_to("wready"); break; end
        end
        @(posedge clk); #1 wvalid = 1'b0;
    endtask

    task automatic issue_aw_w(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int mode);
        case (mode)
            0: fork send_aw(a); send_w(d, s); join
            1: begin send_aw(a); send_w(d, s); end
            default: begin send_w(d, s); send_aw(a); end
        endcase
    endtask

    task automatic wait_bvalid();
        int t = 0;
        do begin @(negedge clk); t++; end while (!bvalid && t < 50);
        if (!bvalid) fail_to("bvalid");
    endtask

    task automatic release_b(input int hold);
        repeat (hold) begin
            @(negedge clk);
            check32("bvalid_hold", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int mode, input int hold);
        model_write(a, d, s);
        issue_aw_w(a, d, s, mode);
        wait_bvalid();
        release_b(hold);
    endtask

    task automatic axi_read(input logic [31:0] a);
        int t = 0;
        int lat = 0;
        rd_q.push_back(model_read(a));
        araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (arready) break;
            t++;
            if (t > 50) begin fail_to("arready"); break; end
        end
        @(posedge clk); #1 arvalid = 1'b0;
        do begin @(negedge clk); lat++; end while (!rvalid && lat < 50);
        check32("read_latency", 32'(lat), 32'd1);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rready = 1'b0;
    endtask

    task automatic start_pulse(input logic [32*IN_W-1:0] v);
        host_in = v; host_start = 1'b1;
        model_start(v);
        @(posedge clk); #1 host_start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_host();
        @(negedge clk);
        check32("host_busy", 32'(host_busy), 32'(m_busy));
        check_wide("host_out", host_out, m_hout);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1);
    end

    initial begin
        logic [32*IN_W-1:0] v;
        for (int i = 0; i < int'(IN_W); i++) m_in[i] = '0;
        for (int j = 0; j < int'(OUT_W); j++) m_out[j] = '0;

        repeat (3) @(negedge clk);
        check32("rst_awready", 32'(awready), 32'd0);
        check32("rst_wready", 32'(wready), 32'd0);
        check32("rst_bvalid", 32'(bvalid), 32'd0);
        check32("rst_arready", 32'(arready), 32'd0);
        check32("rst_rvalid", 32'(rvalid), 32'd0);
        check32("rst_rdata", rdata, 32'd0);
        check32("rst_busy", 32'(host_busy), 32'd0);
        check32("rst_done", 32'(host_done), 32'd0);
        check_wide("rst_host_out", host_out, '0);
        resetn = 1'b1;
        @(posedge clk); #1;

        axi_read(32'h200);
        axi_read(32'h204);

`ifdef CW305_AXI_TIMEOUT_EN
        for (int i = 0; i < int'(IN_W); i++) v[32*i +: 32] = $urandom;
        axi_write(32'h100, 32'h5A5A_5A5A, 4'hF, 0, 0);
        start_pulse(v);
        axi_write(32'h200, 32'h1, 4'hF, 0, 0);
        check_host();
        begin
            int cnt = 0;
            done_q.push_back('0);
            host_in = v; host_start = 1'b1;
            model_start(v);
            @(posedge clk); #1 host_start = 1'b0;
            while (host_busy && cnt < 100) begin
                @(negedge clk);
                if (host_busy) cnt++;
            end
            check32("timeout_cycles", 32'(cnt), 32'(TMO));
            m_busy = 0; m_tmo = 1; m_hout = '0;
            @(posedge clk); #1;
        end
        check_host();
        axi_read(32'h200);
        axi_write(32'h200, 32'h8, 4'hF, 0, 0);
        axi_read(32'h200);
`else
        // Directed snapshot and readback
        for (int i = 0; i < int'(IN_W); i++) v[32*i +: 32] = 32'h1111_1111 * 32'(i + 1);
        start_pulse(v);
        check_host();
        axi_read(32'h01C);
        axi_read(32'h204);

        // Output words with mixed channel order and a partial strobe
        axi_write(32'h100, 32'hA0, 4'hF, 0, 0);
        axi_write(32'h104, 32'hA1, 4'hF, 2, 0);
        axi_write(32'h108, 32'h1234_56A2, 4'b0011, 1, 0);
        axi_write(32'h10C, 32'hA3, 4'hF, 0, 0);
        axi_read(32'h108);
        axi_write(32'h200, 32'h1, 4'hF, 0, 0);
        check_host();

        // Overrun set and clear
        start_pulse(v);
        start_pulse(~v);
        axi_read(32'h200);
        axi_write(32'h200, 32'h2, 4'hF, 0, 0);
        axi_read(32'h200);

        // Response back-pressure with a second write queued behind it
        model_write(32'h104, 32'hB1, 4'hF);
        issue_aw_w(32'h104, 32'hB1, 4'hF, 0);
        wait_bvalid();
        issue_aw_w(32'h108, 32'hC2C2_C2C2, 4'hF, 2);
        axi_read(32'h108);
        model_write(32'h108, 32'hC2C2_C2C2, 4'hF);
        release_b(5);
        wait_bvalid();
        release_b(0);
        axi_read(32'h108);
        axi_read(32'h300);

        // Commit and start land in the same cycle: commit wins, start overruns
        model_write(32'h200, 32'h1, 4'hF);
        m_ovr = 1;
        issue_aw_w(32'h200, 32'h1, 4'hF, 0);
        host_start = 1'b1;
        @(posedge clk); #1 host_start = 1'b0;
        wait_bvalid();
        release_b(0);
        axi_read(32'h200);
        axi_read(32'h204);
        axi_write(32'h200, 32'h2, 4'hF, 0, 0);

        // Start level held across commit is not re-accepted
        for (int i = 0; i < int'(IN_W); i++) v[32*i +: 32] = $urandom;
        host_in = v; host_start = 1'b1;
        model_start(v);
        @(posedge clk); #1;
        axi_read(32'h200);
        axi_write(32'h200, 32'h1, 4'hF, 0, 0);
        axi_read(32'h200);
        axi_read(32'h204);
        host_start = 1'b0;
        @(posedge clk); #1;
        check_host();

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            logic [31:0] a;
            int unsigned op = $urandom_range(0, 9);
            case (op)
                0, 1: begin
                    for (int i = 0; i < int'(IN_W); i++) v[32*i +: 32] = $urandom;
                    start_pulse(v);
                end
                2, 3, 4: begin
                    a = 32'h100 + 32'(4 * $urandom_range(0, OUT_W - 1));
                    a[31:12] = 20'($urandom);
                    axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 2),
                              $urandom_range(0, 2));
                end
                5: axi_write(32'h200, $urandom | 32'h1, 4'hF, $urandom_range(0, 2), 0);
                6: axi_write(rand_addr(), $urandom, 4'hF, $urandom_range(0, 2), 0);
                default: axi_read(rand_addr());
            endcase
            if (it % 10 == 0) check_host();
        end
`endif

        repeat (5) @(negedge clk);
        check32("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        check32("done_queue_empty", 32'(done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
